// File: rtl/rom_loader_pkg.sv
// Shared constants for the ROM loader handshake: FSM encoding and default widths,
// also used by the initiator model and the SoC top.
package rom_loader_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_MAX_WORDS  = 32768;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

endpackage

// File: rtl/rom_loader_responder.sv
// SoC-side ROM loader responder: captures one word per load high period, writes it
// to the ROM controller at an auto-incrementing address, then acknowledges it.
module rom_loader_responder
  import rom_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int MAX_WORDS  = DEF_MAX_WORDS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rom_loader_reset,
  input  logic                  rom_loader_load,
  input  logic [DATA_WIDTH-1:0] rom_loader_data,
  output logic                  rom_loader_load_received,
  output logic                  rom_loader_ack,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_done,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0] CAP = (ADDR_WIDTH+1)'(MAX_WORDS);

  logic [1:0]            state;
  logic [ADDR_WIDTH:0]   count;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  pending_restart;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      count           <= '0;
      wdata_q         <= '0;
      pending_restart <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // restart beats a simultaneous load: nothing is captured
          if (rom_loader_reset) begin
            count    <= '0;
            overflow <= 1'b0;
          end else if (rom_loader_load) begin
            wdata_q <= rom_loader_data;
            if (count < CAP) begin
              state <= ST_WRITE;
            end else begin
              overflow <= 1'b1;
              state    <= ST_ACK;
            end
          end
        end
        ST_WRITE: begin
          // a restart mid-write must let the controller finish; remember it
          if (rom_loader_reset)
            pending_restart <= 1'b1;
          if (mem_done) begin
            if (pending_restart || rom_loader_reset) begin
              state           <= ST_IDLE;
              count           <= '0;
              overflow        <= 1'b0;
              pending_restart <= 1'b0;
            end else begin
              state <= ST_ACK;
              count <= count + 1'b1;
            end
          end
        end
        ST_ACK: begin
          if (rom_loader_reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            overflow <= 1'b0;
          end else if (!rom_loader_load) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // count never exceeds CAP and WRITE is only entered below it, so the
  // truncated address stays within MAX_WORDS-1
  assign mem_req                  = (state == ST_WRITE);
  assign mem_addr                 = count[ADDR_WIDTH-1:0];
  assign mem_wdata                = wdata_q;
  assign rom_loader_ack           = (state == ST_ACK);
  assign rom_loader_load_received = (state != ST_IDLE);
  assign words_loaded             = count;

endmodule

// File: tb/tb_rom_loader_responder.sv
// Directed bench for rom_loader_responder: a full-size instance for the handshake
// scenarios and a MAX_WORDS=2 instance for the overflow path.
module tb_rom_loader_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_rst, ld, done;
  logic [15:0] ld_data;
  logic        lrcv, ack, mem_req, ovf;
  logic [15:0] mem_addr, mem_wdata;
  logic [16:0] words;

  logic        b_rst, b_ld, b_done;
  logic [15:0] b_data;
  logic        b_lrcv, b_ack, b_req, b_ovf;
  logic [15:0] b_addr, b_wdata;
  logic [16:0] b_words;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int wr_a    = 0;
  int wr_b    = 0;
  logic req_a_q = 1'b0;
  logic req_b_q = 1'b0;
  logic saw_ffff = 1'b0;

  always #5 clk = ~clk;

  rom_loader_responder dut (
    .clk(clk), .reset(reset),
    .rom_loader_reset(ld_rst), .rom_loader_load(ld), .rom_loader_data(ld_data),
    .rom_loader_load_received(lrcv), .rom_loader_ack(ack),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_done(done),
    .words_loaded(words), .overflow(ovf)
  );

  rom_loader_responder #(.MAX_WORDS(2)) dut_small (
    .clk(clk), .reset(reset),
    .rom_loader_reset(b_rst), .rom_loader_load(b_ld), .rom_loader_data(b_data),
    .rom_loader_load_received(b_lrcv), .rom_loader_ack(b_ack),
    .mem_req(b_req), .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_done(b_done),
    .words_loaded(b_words), .overflow(b_ovf)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // write-request monitors: count rising edges of mem_req, watch for stale data
  always @(negedge clk) begin
    req_a_q <= mem_req;
    req_b_q <= b_req;
    if (mem_req && !req_a_q) wr_a <= wr_a + 1;
    if (b_req && !req_b_q)   wr_b <= wr_b + 1;
    if (mem_req && mem_wdata == 16'hFFFF) saw_ffff <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one word, answer mem_done dly cycles after mem_req rises, leave load high at ack.
  task automatic put_word(input logic [15:0] d, input int dly, input logic [15:0] exp_addr);
    int t0;
    @(negedge clk); ld = 1'b1; ld_data = d; t0 = cyc;
    @(negedge clk);
    chk("req", 32'(mem_req), 1);
    chk("addr", 32'(mem_addr), 32'(exp_addr));
    chk("wdata", 32'(mem_wdata), 32'(d));
    chk("lrcv_write", 32'(lrcv), 1);
    repeat (dly) @(negedge clk);
    chk("req_hold", 32'(mem_req), 1);
    done = 1'b1;
    @(negedge clk); done = 1'b0;
    chk("ack", 32'(ack), 1);
    chk("req_off", 32'(mem_req), 0);
    chk("latency", 32'(cyc - t0), 32'(dly + 2));
  endtask

  task automatic drop_load();
    @(negedge clk); ld = 1'b0;
    @(negedge clk);
    chk("ack_clear", 32'(ack), 0);
    chk("lrcv_clear", 32'(lrcv), 0);
  endtask

  initial begin
    int wr0;
    reset = 1'b1; ld_rst = 1'b0; ld = 1'b0; done = 1'b0; ld_data = '0;
    b_rst = 1'b0; b_ld = 1'b0; b_done = 1'b0; b_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_lrcv", 32'(lrcv), 0);
    chk("rst_words", 32'(words), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_addr", 32'(mem_addr), 0);

    // single word, mem_done three cycles after mem_req: ack at load+5
    put_word(16'h7FFF, 3, 16'd0);
    chk("single_words", 32'(words), 1);
    drop_load();

    // restart in IDLE, then a burst of four with immediate mem_done
    @(negedge clk); ld_rst = 1'b1;
    @(negedge clk); ld_rst = 1'b0;
    chk("restart_words", 32'(words), 0);
    wr0 = wr_a;
    put_word(16'h0010, 0, 16'd0); drop_load();
    put_word(16'hEC10, 0, 16'd1); drop_load();
    put_word(16'h0000, 0, 16'd2); drop_load();
    put_word(16'hE308, 0, 16'd3); drop_load();
    chk("burst_words", 32'(words), 4);
    chk("burst_writes", 32'(wr_a - wr0), 4);

    // load held long after ack with changing data: exactly one write
    wr0 = wr_a;
    put_word(16'h5A5A, 1, 16'd4);
    ld_data = 16'hFFFF;
    repeat (20) @(negedge clk);
    chk("held_ack", 32'(ack), 1);
    chk("held_writes", 32'(wr_a - wr0), 1);
    chk("held_no_ffff", 32'(saw_ffff), 0);
    drop_load();
    chk("held_words", 32'(words), 5);

    // restart while writing address 5: write completes, no ack, count cleared
    @(negedge clk); ld = 1'b1; ld_data = 16'h1234;
    @(negedge clk);
    chk("rw_addr", 32'(mem_addr), 5);
    ld_rst = 1'b1;
    @(negedge clk); ld_rst = 1'b0;
    chk("rw_req_hold1", 32'(mem_req), 1);
    @(negedge clk);
    chk("rw_req_hold2", 32'(mem_req), 1);
    done = 1'b1; ld = 1'b0;
    @(negedge clk); done = 1'b0;
    chk("rw_no_ack", 32'(ack), 0);
    chk("rw_lrcv", 32'(lrcv), 0);
    chk("rw_words", 32'(words), 0);
    put_word(16'h0042, 0, 16'd0);
    drop_load();

    // restart and load together in IDLE: restart wins, then the load goes to address 0
    @(negedge clk); ld_rst = 1'b1; ld = 1'b1; ld_data = 16'hBEEF;
    @(negedge clk); ld_rst = 1'b0;
    chk("rl_lrcv", 32'(lrcv), 0);
    chk("rl_req", 32'(mem_req), 0);
    chk("rl_words", 32'(words), 0);
    @(negedge clk);
    chk("rl_req2", 32'(mem_req), 1);
    chk("rl_addr", 32'(mem_addr), 0);
    chk("rl_wdata", 32'(mem_wdata), 32'h0000BEEF);
    done = 1'b1;
    @(negedge clk); done = 1'b0;
    chk("rl_ack", 32'(ack), 1);
    drop_load();

    // load dropped before ack: ack still shown for exactly one cycle
    @(negedge clk); ld = 1'b1; ld_data = 16'h00AA;
    @(negedge clk);
    chk("ed_addr", 32'(mem_addr), 1);
    done = 1'b1; ld = 1'b0;
    @(negedge clk); done = 1'b0;
    chk("ed_ack", 32'(ack), 1);
    @(negedge clk);
    chk("ed_ack_gone", 32'(ack), 0);
    chk("ed_words", 32'(words), 2);

    // capacity of two: third load acked without a write, overflow sticks
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); b_ld = 1'b1; b_data = 16'(16'h0100 + i);
      @(negedge clk);
      if (i < 2) begin
        chk("ov_req", 32'(b_req), 1);
        chk("ov_addr", 32'(b_addr), 32'(i));
        b_done = 1'b1;
        @(negedge clk); b_done = 1'b0;
      end
      chk("ov_ack", 32'(b_ack), 1);
      chk("ov_req_off", 32'(b_req), 0);
      @(negedge clk); b_ld = 1'b0;
      @(negedge clk);
    end
    chk("ov_flag", 32'(b_ovf), 1);
    chk("ov_words", 32'(b_words), 2);
    chk("ov_writes", 32'(wr_b), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
